// File: rtl/new_game_button_pkg.sv
// new_game_button_pkg
//   Shared types and constants for the new-game button path.
//   - db_state_t    : debounce FSM state encoding
//   - NEW_GAME_ADDR : word address of the status word; a store here
//                     acknowledges a press (also used by the RAM instance)
package new_game_button_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } db_state_t;

  localparam int NEW_GAME_ADDR = 0;

endpackage

// File: rtl/new_game_button_debounce_fsm.sv
// debounce_fsm
//   Two-flop synchronizer followed by a four-state debounce FSM.
//   Ports:
//     clk, reset_n : clock, synchronous active-low reset
//     btn_raw      : asynchronous raw button level
//     press        : one-cycle pulse, high in the cycle whose edge
//                    performs the CHK_HIGH -> IDLE_HIGH transition
//     btn_level    : registered debounced level
module debounce_fsm
  import new_game_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic press,
  output logic btn_level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      state     <= IDLE_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_level <= level_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    unique case (state)
      IDLE_LOW:
        if (sync2) begin
          state_nxt = CHK_HIGH;
          cnt_nxt   = '0;
        end
      CHK_HIGH:
        if (!sync2)             state_nxt = IDLE_LOW;
        else if (cnt == CNT_MAX) begin
          state_nxt = IDLE_HIGH;
          press     = 1'b1;
        end else                cnt_nxt = cnt + CNT_W'(1);
      IDLE_HIGH:
        if (!sync2) begin
          state_nxt = CHK_LOW;
          cnt_nxt   = '0;
        end
      CHK_LOW:
        // release is confirmed silently; no event on the falling side
        if (sync2)              state_nxt = IDLE_HIGH;
        else if (cnt == CNT_MAX) state_nxt = IDLE_LOW;
        else                    cnt_nxt = cnt + CNT_W'(1);
      default:                  state_nxt = IDLE_LOW;
    endcase
  end

  // level follows the next state so it moves on the same edge as the FSM
  assign level_nxt = (state_nxt == IDLE_HIGH) || (state_nxt == CHK_LOW);

endmodule

// File: rtl/new_game_button.sv
// new_game_button
//   Conditions the raw new-game button and holds a sticky newGame flag
//   for the RAM status word until the processor stores to CLEAR_ADDR.
//   Ports:
//     clk, reset_n : clock, synchronous active-low reset
//     btn_raw      : asynchronous raw button, active-high
//     wEn, addr    : processor store strobe / address (shared with RAM)
//     dataIn       : processor store data, unused here
//     newGame      : sticky press flag to the RAM
//     btn_level    : debounced button level
//     press_count  : confirmed presses modulo 256
module new_game_button
  import new_game_button_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 12,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CLEAR_ADDR      = NEW_GAME_ADDR
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     btn_raw,
  input  logic                     wEn,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    dataIn,
  output logic                     newGame,
  output logic                     btn_level,
  output logic [7:0]               press_count
);

  logic press;
  logic clr;
  logic unused_data;

  assign unused_data = ^dataIn;

  debounce_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_raw  (btn_raw),
    .press    (press),
    .btn_level(btn_level)
  );

  assign clr = wEn && (addr == ADDRESS_WIDTH'(CLEAR_ADDR));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      newGame     <= 1'b0;
      press_count <= 8'd0;
    end else begin
      // a press on the same edge as the acknowledge store must not be lost
      if (press)    newGame <= 1'b1;
      else if (clr) newGame <= 1'b0;
      if (press)    press_count <= press_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_new_game_button.sv
module tb_new_game_button;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_raw;
  logic        wEn;
  logic [11:0] addr;
  logic [31:0] dataIn;
  logic        newGame;
  logic        btn_level;
  logic [7:0]  press_count;

  int n_chk  = 0;
  int n_fail = 0;

  new_game_button #(
    .DATA_WIDTH     (32),
    .ADDRESS_WIDTH  (12),
    .DEBOUNCE_CYCLES(4),
    .CLEAR_ADDR     (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .wEn        (wEn),
    .addr       (addr),
    .dataIn     (dataIn),
    .newGame    (newGame),
    .btn_level  (btn_level),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // k edges, then settle 1 time unit past the last one
  task automatic tick(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [11:0] a);
    wEn = 1'b1; addr = a; dataIn = $urandom;
    tick(1);
    wEn = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; btn_raw = 1'b1; wEn = 1'b0; addr = '0; dataIn = '0;

    // reset held with button high
    tick(3);
    chk("rst_newGame", newGame, 0);
    chk("rst_level",   btn_level, 0);
    chk("rst_count",   press_count, 0);

    // release reset: first unreset edge is edge 0
    reset_n = 1'b1;
    tick(6);
    chk("rst_rel_e5_ng", newGame, 0);
    tick(1);
    chk("rst_rel_e6_ng", newGame, 1);
    chk("rst_rel_e6_cnt", press_count, 1);

    btn_raw = 1'b0;
    tick(5);
    chk("release_e4_level", btn_level, 1);
    tick(3);
    chk("release_level", btn_level, 0);
    chk("release_keeps_ng", newGame, 1);
    store(12'd0);
    chk("clear_ng", newGame, 0);

    // clean press
    btn_raw = 1'b1;
    tick(6);
    chk("clean_e5_ng",    newGame, 0);
    chk("clean_e5_level", btn_level, 0);
    chk("clean_e5_cnt",   press_count, 1);
    tick(1);
    chk("clean_e6_ng",    newGame, 1);
    chk("clean_e6_level", btn_level, 1);
    chk("clean_e6_cnt",   press_count, 2);
    btn_raw = 1'b0;
    tick(10);
    store(12'd0);
    chk("clean_clear", newGame, 0);

    // glitches of 3 and 4 cycles rejected, 5 accepted
    for (int n = 3; n <= 5; n++) begin
      btn_raw = 1'b1;
      tick(n);
      btn_raw = 1'b0;
      tick(12);
      chk($sformatf("glitch%0d_ng", n),    newGame,     (n == 5) ? 1 : 0);
      chk($sformatf("glitch%0d_cnt", n),   press_count, (n == 5) ? 3 : 2);
      chk($sformatf("glitch%0d_level", n), btn_level,   0);
    end

    // loads and stores elsewhere leave the flag alone; store to 0 clears
    wEn = 1'b0; addr = 12'd0; dataIn = 32'hFFFF_FFFF;
    tick(2);
    chk("load_no_clear", newGame, 1);
    store(12'd5);
    chk("other_addr_no_clear", newGame, 1);
    store(12'd0);
    chk("store_clear", newGame, 0);

    // clearing store on the same edge as a press event
    btn_raw = 1'b1;
    tick(6);
    chk("setclr_e5_ng", newGame, 0);
    store(12'd0);
    chk("set_beats_clear", newGame, 1);
    chk("set_beats_clear_cnt", press_count, 4);
    btn_raw = 1'b0;
    tick(10);

    // counter wrap from a fresh reset
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    chk("wrap_start_cnt", press_count, 0);
    for (int i = 0; i < 256; i++) begin
      btn_raw = 1'b1;
      tick(8);
      if (i == 254) chk("wrap_255", press_count, 255);
      if (i == 255) chk("wrap_ng_pressed", newGame, 1);
      btn_raw = 1'b0;
      tick(8);
    end
    chk("wrap_cnt",   press_count, 0);
    chk("wrap_ng",    newGame, 1);
    chk("wrap_level", btn_level, 0);

    // reset during CHK_HIGH discards the pending press
    store(12'd0);
    btn_raw = 1'b1;
    tick(4);
    reset_n = 1'b0;
    tick(3);
    chk("midrst_ng",    newGame, 0);
    chk("midrst_level", btn_level, 0);
    chk("midrst_cnt",   press_count, 0);
    reset_n = 1'b1;
    tick(6);
    chk("midrst_e5_ng", newGame, 0);
    tick(1);
    chk("midrst_e6_ng",    newGame, 1);
    chk("midrst_e6_level", btn_level, 1);
    chk("midrst_e6_cnt",   press_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/new_game_button.md
# new_game_button

Input-conditioning stage directly upstream of the data RAM's status word. It takes the raw, asynchronous "new game" push-button and runs it through a two-flop synchronizer and a debounce state machine. Each confirmed press sets a sticky `newGame` flag, which feeds the RAM's `newGame` input so that word 0 reflects it. The flag stays set until the processor acknowledges it with a store to the clear address, so a press is never missed between processor polls.

## Interface
Parameters:
- `DATA_WIDTH`, 32: processor store-data width; must match the RAM.
- `ADDRESS_WIDTH`, 12: processor address width; must match the RAM.
- `DEBOUNCE_CYCLES`, 16: cycles the synchronized input must hold a new level before it is accepted. Must be ≥ 2. Set large (e.g. 1_000_000) for the board build.
- `CLEAR_ADDR`, 0: word address whose store clears `newGame`.

Ports (clock and reset first):
- `clk` in 1: system clock; the same clock as the RAM and processor.
- `reset_n` in 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `btn_raw` in 1: raw button level, asynchronous to `clk`, active-high.
- `wEn` in 1: processor store strobe; the same net as the RAM's `wEn`.
- `addr` in `ADDRESS_WIDTH`: processor address; the same net as the RAM's `addr`.
- `dataIn` in `DATA_WIDTH`: processor store data. Ignored by this block; present only for bus symmetry.
- `newGame` out 1: sticky press flag; connects to the RAM's `newGame`.
- `btn_level` out 1: debounced button level.
- `press_count` out 8: count of confirmed presses, modulo 256.

One clock domain; reset is synchronous and active-low. All outputs are registered.

## Operation
- **Synchronizer:** `sync1 <= btn_raw`, then `sync2 <= sync1`. Both flops reset to 0. Only `sync2` is used downstream.
- **Debounce FSM:** four states, `IDLE_LOW`, `CHK_HIGH`, `IDLE_HIGH`, `CHK_LOW`, plus counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`.
  - `IDLE_LOW`: if `sync2` = 1, go to `CHK_HIGH` and set `cnt` to 0.
  - `CHK_HIGH`:
    - If `sync2` = 0, go back to `IDLE_LOW` (glitch rejected).
    - Else if `cnt` = `DEBOUNCE_CYCLES-1`, go to `IDLE_HIGH` and emit a press event.
    - Else increment `cnt`.
  - `IDLE_HIGH`: if `sync2` = 0, go to `CHK_LOW` and set `cnt` to 0.
  - `CHK_LOW`:
    - If `sync2` = 1, go back to `IDLE_HIGH`.
    - Else if `cnt` = `DEBOUNCE_CYCLES-1`, go to `IDLE_LOW`. No event is emitted on release.
    - Else increment `cnt`.
- **`btn_level`:** 1 in `IDLE_HIGH` and `CHK_LOW`, 0 otherwise. It is registered and updates on the same edge as the state change.
- **Press event** (the `CHK_HIGH` to `IDLE_HIGH` transition):
  - sets `newGame` to 1;
  - increments `press_count`, wrapping from 255 to 0.
- **Clear:** `wEn` = 1 and `addr` = `CLEAR_ADDR` clears `newGame` to 0 on that edge. The value of `dataIn` is irrelevant.
- **Set and clear on the same edge:** set wins, and `newGame` stays 1.
- **Processor loads:** loads (`wEn` = 0) never affect `newGame`.
- **Reset values:** while `reset_n` = 0 at an edge, state goes to `IDLE_LOW` and `cnt`, `sync1`, `sync2`, `newGame`, `btn_level` and `press_count` all go to 0. A reset in the middle of `CHK_HIGH` discards the pending press.

## Timing
- **Press latency:** if `btn_raw` is first sampled 1 at edge 0 and held, `btn_level`, `newGame` and `press_count` all update after edge `DEBOUNCE_CYCLES+2`:
  - edges 0–1: synchronizer;
  - edge 2: enter `CHK_HIGH`;
  - edges 3 to `DEBOUNCE_CYCLES+1`: `cnt` counts up;
  - edge `DEBOUNCE_CYCLES+2`: transition and press event.
- **Glitch rejection:** a high pulse on `sync2` lasting ≤ `DEBOUNCE_CYCLES` cycles produces no event.
- **Release latency:** symmetric; `btn_level` falls after edge `DEBOUNCE_CYCLES+2` relative to the first low sample.
- **Clear latency:** `newGame` reads 0 in the cycle after the clearing store edge.
- **RAM word 0 lag:** the RAM copies `newGame` into word 0 on the next edge, so word 0 lags `newGame` by one cycle. Software must tolerate this.
- **Handshake:** none beyond the clear store. Further presses while `newGame` = 1 still increment `press_count` but do not stack the flag.

## Structure
- Shared package holds:
  - the debounce state enum (`IDLE_LOW`, `CHK_HIGH`, `IDLE_HIGH`, `CHK_LOW`);
  - the `NEW_GAME_ADDR` constant (0), which is also used by the RAM instantiation.
- Sub-module `debounce_fsm`: synchronizer, FSM, counter and `btn_level`, with a one-cycle `press` pulse output. The top level adds the sticky flag, the clear decode and `press_count`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- **Reset:** hold `reset_n` = 0 for 3 cycles with `btn_raw` = 1 → all outputs 0. Release reset → `newGame` = 1 after edge 6 counted from the first unreset edge.
- **Clean press:** `btn_raw` rises before edge 0 and is held → `newGame` = 1, `btn_level` = 1 and `press_count` = 1 after edge 6, not after edge 5.
- **Glitch:** `btn_raw` high for 3 cycles, then low → `newGame`, `btn_level` and `press_count` stay 0. Repeat with 4 cycles → still 0. Repeat with 5 cycles → press registered.
- **Clear with a load and set-beats-clear:**
  - `wEn` = 1, `addr` = 0 → `newGame` = 0 next cycle.
  - `wEn` = 0, `addr` = 0 (a load) → no change.
  - Store to `addr` = 0 on the same edge as a press event → `newGame` = 1.
- **Counter wrap:** 256 clean presses → `press_count` = 0 and `newGame` = 1. Release of the button leaves `newGame` unchanged.
- **Mid-debounce reset:** pull `reset_n` = 0 at edge 4 of a press → no event, state `IDLE_LOW`. With `btn_raw` still high, the press is detected 6 edges after reset is released.
